ft_system_unit: RTL and testbench

- Fault-tolerant register-file write stage for a lockstep pair of processing channels (A and B).
- Each cycle it compares the two redundant write requests and commits to a 32x32 register file only when both channels agree.
- Reports the committed write and a 6-bit fault/status vector to the surrounding system.
- Provides one registered read port for state readback.

---
 rtl/ft_system_unit.sv | 174 +++++++++++++++++
 tb/tb_ft_system_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ft_system_unit.sv
// ft_system_unit -- fault-tolerant register-file write stage for a lockstep
// pair of channels (A and B). A write commits only when both channels request
// the same write. Status is reported on a registered 6-bit vector.
//
// Optional feature macro: FT_PARITY_EN
//   defined   : each register stores an even-parity bit; readback checks it
//               and flags signal[5] (and the sticky error signal[4]).
//   undefined : no parity storage, signal[5] tied to 0.
//
// Request semantics: there is no handshake. Each channel presents its write
// request (we/addr/data) for exactly the cycle it is sampled. The unit always
// accepts; disagreement is reported, never stalled.
//
// Status vector (signal):
//   [0] commit       one-cycle pulse
//   [1] we_mis       one-cycle pulse
//   [2] addr_mis     one-cycle pulse
//   [3] data_mis     one-cycle pulse
//   [4] sticky error set on any fault (or parity error), cleared by err_clr_i;
//                    setting wins over clearing
//   [5] parity error aligned with the rdata_o it refers to

module ft_system_unit #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_a_i,
   input  logic              we_b_i,
   input  logic [ADDR_W-1:0] addr_a_i,
   input  logic [ADDR_W-1:0] addr_b_i,
   input  logic [DATA_W-1:0] data_a_i,
   input  logic [DATA_W-1:0] data_b_i,
   input  logic [ADDR_W-1:0] raddr_i,
   input  logic              err_clr_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic [5:0]        signal
);

   localparam int DEPTH = 2 ** ADDR_W;

   // ------------------------------------------------------------------
   // Channel comparison
   // ------------------------------------------------------------------
   logic w_any_we;
   logic w_we_mis;
   logic w_addr_mis;
   logic w_data_mis;
   logic w_fault;
   logic w_commit;
   logic w_par_err;

   // Compare the redundant requests; a commit needs agreement on everything.
   always_comb begin
      w_any_we   = we_a_i | we_b_i;
      w_we_mis   = we_a_i ^ we_b_i;
      w_addr_mis = w_any_we & (addr_a_i != addr_b_i);
      w_data_mis = w_any_we & (data_a_i != data_b_i);
      w_fault    = w_we_mis | w_addr_mis | w_data_mis;
      w_commit   = we_a_i & we_b_i & ~w_fault;
   end

   // ------------------------------------------------------------------
   // Register file (all entries reset, address 0 is an ordinary register)
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write the agreed data on commit; faulty requests never touch storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_commit) begin
         r_mem[addr_a_i] <= data_a_i;
      end
   end

`ifdef FT_PARITY_EN
   // Even parity per entry: the stored bit makes the total count of ones even.
   logic [DEPTH-1:0] r_par;

   // Capture parity of the committed data alongside the data itself.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_par <= '0;
      end else if (w_commit) begin
         r_par[addr_a_i] <= ^data_a_i;
      end
   end

   // Recompute parity on the entry being read; registered with rdata_o below.
   always_comb begin
      w_par_err = (^r_mem[raddr_i]) ^ r_par[raddr_i];
   end
`else
   // Parity disabled: never report a parity error.
   always_comb begin
      w_par_err = 1'b0;
   end
`endif

   // ------------------------------------------------------------------
   // Committed-write report and readback port
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_rdata;

   // Latch the last committed write; hold across idle and faulty cycles.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_addr <= '0;
         r_data <= '0;
      end else if (w_commit) begin
         r_addr <= addr_a_i;
         r_data <= data_a_i;
      end
   end

   // Registered readback; a same-cycle commit to raddr_i returns the old data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[raddr_i];
      end
   end

   // ------------------------------------------------------------------
   // Status vector
   // ------------------------------------------------------------------
   logic [3:0] r_pulse;
   logic       r_sticky;
   logic       r_par_flag;

   // One-cycle pulses describing what happened on the previous edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pulse <= '0;
      end else begin
         r_pulse <= {w_data_mis, w_addr_mis, w_we_mis, w_commit};
      end
   end

   // Sticky error: any new error sets it, even when a clear arrives alongside.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sticky <= 1'b0;
      end else if (w_fault | w_par_err) begin
         r_sticky <= 1'b1;
      end else if (err_clr_i) begin
         r_sticky <= 1'b0;
      end
   end

   // Parity flag registered on the same edge as rdata_o so the two line up.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_par_flag <= 1'b0;
      end else begin
         r_par_flag <= w_par_err;
      end
   end

   assign addr_o  = r_addr;
   assign data_o  = r_data;
   assign rdata_o = r_rdata;
   assign signal  = {r_par_flag, r_sticky, r_pulse};

endmodule

// File: tb/tb_ft_system_unit.sv
// Directed testbench for ft_system_unit: a linear sequence of steps with
// hand-computed expected values, each compared by an immediate assertion.
// FT_PARITY_EN enables the stored-parity corruption step.

module tb_ft_system_unit;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   // ------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------
   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              we_a_i, we_b_i;
   logic [ADDR_W-1:0] addr_a_i, addr_b_i;
   logic [DATA_W-1:0] data_a_i, data_b_i;
   logic [ADDR_W-1:0] raddr_i;
   logic              err_clr_i;
   logic [ADDR_W-1:0] addr_o;
   logic [DATA_W-1:0] data_o;
   logic [DATA_W-1:0] rdata_o;
   logic [5:0]        signal;

   always #5 clk_i = ~clk_i;

   ft_system_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .we_a_i    (we_a_i),
      .we_b_i    (we_b_i),
      .addr_a_i  (addr_a_i),
      .addr_b_i  (addr_b_i),
      .data_a_i  (data_a_i),
      .data_b_i  (data_b_i),
      .raddr_i   (raddr_i),
      .err_clr_i (err_clr_i),
      .addr_o    (addr_o),
      .data_o    (data_o),
      .rdata_o   (rdata_o),
      .signal    (signal)
   );

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic drive(input logic wa, input logic wb,
                        input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ab,
                        input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db);
      we_a_i   = wa;
      we_b_i   = wb;
      addr_a_i = aa;
      addr_b_i = ab;
      data_a_i = da;
      data_b_i = db;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, '0, '0);
      err_clr_i = 1'b0;
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      rst_ni  = 1'b0;
      raddr_i = '0;
      idle();
      tick();
      tick();
      check("reset_addr_o",  32'(addr_o), 32'd0);
      check("reset_data_o",  data_o,      32'd0);
      check("reset_rdata_o", rdata_o,     32'd0);
      check("reset_signal",  32'(signal), 32'd0);
      rst_ni = 1'b1;
      tick();

      // Basic commit: reg[10] = 100
      drive(1'b1, 1'b1, 5'd10, 5'd10, 32'd100, 32'd100);
      tick();
      check("commit_addr_o", 32'(addr_o), 32'd10);
      check("commit_data_o", data_o,      32'd100);
      check("commit_signal", 32'(signal), 32'b000001);
      idle();
      raddr_i = 5'd10;
      tick();
      check("commit_readback", rdata_o,    32'd100);
      check("commit_pulse_gone", 32'(signal), 32'd0);

      // Data fault: no write, outputs hold
      drive(1'b1, 1'b1, 5'd10, 5'd10, 32'd100, 32'd101);
      tick();
      check("dfault_signal", 32'(signal), 32'b011000);
      check("dfault_addr_o", 32'(addr_o), 32'd10);
      check("dfault_data_o", data_o,      32'd100);
      idle();
      tick();
      check("dfault_readback", rdata_o,    32'd100);
      check("dfault_sticky",  32'(signal), 32'b010000);

      // Address fault, then write-enable fault
      drive(1'b1, 1'b1, 5'd10, 5'd11, 32'd55, 32'd55);
      tick();
      check("afault_signal", 32'(signal), 32'b010100);
      drive(1'b1, 1'b0, 5'd12, 5'd12, 32'd9, 32'd9);
      tick();
      check("wefault_signal", 32'(signal), 32'b010010);
      check("wefault_data_o", data_o,      32'd100);
      idle();
      raddr_i = 5'd11;
      tick();
      check("afault_reg11", rdata_o, 32'd0);
      raddr_i = 5'd12;
      tick();
      check("wefault_reg12", rdata_o, 32'd0);
      raddr_i = 5'd10;
      tick();
      check("afault_reg10", rdata_o, 32'd100);

      // Sticky hold, clear, and set-wins-over-clear
      tick();
      check("sticky_hold", 32'(signal), 32'b010000);
      err_clr_i = 1'b1;
      tick();
      check("sticky_clear", 32'(signal), 32'd0);
      drive(1'b1, 1'b1, 5'd5, 5'd5, 32'd1, 32'd2);
      err_clr_i = 1'b1;
      tick();
      check("sticky_set_wins", 32'(signal), 32'b011000);
      idle();
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      check("sticky_clear2", 32'(signal), 32'd0);

      // Read during write: old value first, new value next cycle
      drive(1'b1, 1'b1, 5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF);
      raddr_i = 5'd3;
      tick();
      check("rdw_old",     rdata_o,     32'd0);
      check("rdw_signal",  32'(signal), 32'b000001);
      check("rdw_data_o",  data_o,      32'hDEADBEEF);
      idle();
      tick();
      check("rdw_new", rdata_o, 32'hDEADBEEF);

      // Address 0 is writable
      drive(1'b1, 1'b1, 5'd0, 5'd0, 32'd7, 32'd7);
      tick();
      check("addr0_addr_o", 32'(addr_o), 32'd0);
      check("addr0_data_o", data_o,      32'd7);
      idle();
      raddr_i = 5'd0;
      tick();
      check("addr0_readback", rdata_o, 32'd7);

      // Neither channel writing: differing addr/data is not a fault
      drive(1'b0, 1'b0, 5'd1, 5'd2, 32'd3, 32'd4);
      tick();
      check("nowrite_signal", 32'(signal), 32'd0);
      check("nowrite_data_o", data_o,      32'd7);

      // Reset in the middle of a commit
      drive(1'b1, 1'b1, 5'd10, 5'd10, 32'h1234, 32'h1234);
      raddr_i = 5'd3;
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("midrst_addr_o",  32'(addr_o), 32'd0);
      check("midrst_data_o",  data_o,      32'd0);
      check("midrst_rdata_o", rdata_o,     32'd0);
      check("midrst_signal",  32'(signal), 32'd0);
      idle();
      raddr_i = 5'd10;
      #1;
      rst_ni = 1'b1;
      tick();
      check("midrst_reg10", rdata_o, 32'd0);
      raddr_i = 5'd3;
      tick();
      check("midrst_reg3", rdata_o, 32'd0);

`ifdef FT_PARITY_EN
      // Corrupt the stored parity bit of reg 10 and read it back
      drive(1'b1, 1'b1, 5'd10, 5'd10, 32'h1, 32'h1);
      tick();
      idle();
      dut.r_par[10] = ~dut.r_par[10];
      raddr_i = 5'd10;
      tick();
      check("parity_rdata",  rdata_o,     32'h1);
      check("parity_signal", 32'(signal), 32'b110000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
